// File: rtl/spi_dual_arbiter.sv
// Two-requester SPI master: round-robin grant, mode-0 transfer of DATA_W bits MSB first,
// with chip-select setup, hold and inter-transfer gap.
module spi_dual_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] tx0_i,
  input  logic [DATA_W-1:0] tx1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rx0_o,
  output logic [DATA_W-1:0] rx1_o,
  output logic              busy_o,
  output logic [1:0]        cs,
  output logic              SPI_CSN,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);
  localparam int unsigned    HalfW    = $clog2(2 * DATA_W);
  localparam logic [HalfW-1:0] LastHalf = HalfW'(2 * DATA_W - 1);
  localparam logic [7:0]     DivLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0]     GapLast  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
  logic              gnt_q, gnt_d, last_q, last_d, rst_q;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d;
  logic [1:0]        cs_q, cs_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              grant_en, grant_sel;

  // No grant in the first cycle after reset; a lone request wins, contention alternates.
  always_comb begin
    grant_en  = (state_q == StIdle) && !rst && !rst_q && (req0_i || req1_i);
    grant_sel = (req0_i && req1_i) ? ~last_q : req1_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx0_d   = rx0_q;
    rx1_d   = rx1_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    cs_d    = cs_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_en) begin
          state_d = StSetup;
          cnt_d   = DivLast;
          gnt_d   = grant_sel;
          last_d  = grant_sel;
          tx_sh_d = grant_sel ? tx1_i : tx0_i;
          mosi_d  = grant_sel ? tx1_i[DATA_W-1] : tx0_i[DATA_W-1];
          csn_d   = 1'b0;
          cs_d    = grant_sel ? 2'b01 : 2'b10;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          // Entering SHIFT is the first rising SCLK edge.
          state_d = StShift;
          cnt_d   = DivLast;
          half_d  = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], SPI_MISO};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          cnt_d = DivLast;
          if (half_q == LastHalf) begin
            state_d = StHold;
            sclk_d  = 1'b0;
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_sh_d = {rx_sh_q[DATA_W-2:0], SPI_MISO};
            end else begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_q[DATA_W-2];
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLast;
          csn_d   = 1'b1;
          cs_d    = 2'b11;
          mosi_d  = 1'b0;
          if (gnt_q) begin
            rx1_d   = rx_sh_q;
            done1_d = 1'b1;
          end else begin
            rx0_d   = rx_sh_q;
            done0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      cs_q    <= 2'b11;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx0_q   <= rx0_d;
      rx1_q   <= rx1_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      cs_q    <= cs_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign ack0_o   = grant_en & ~grant_sel;
  assign ack1_o   = grant_en & grant_sel;
  assign done0_o  = done0_q & ~rst;
  assign done1_o  = done1_q & ~rst;
  assign busy_o   = (state_q != StIdle) & ~rst;
  assign rx0_o    = rx0_q;
  assign rx1_o    = rx1_q;
  assign cs       = cs_q;
  assign SPI_CSN  = csn_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: doc/spi_dual_arbiter.md
SPI_DUAL_ARBITER -- requirements
Module: spi_dual_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: bits per SPI transfer, MSB first.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
REQ-003 Parameter CS_GAP, default 2: minimum clk cycles with SPI_CSN high between transfers; legal range 1..255.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0_i / req1_i  input  1  transfer request from requester 0 / 1, level-sensitive.
REQ-007 tx0_i / tx1_i  input  DATA_W  word to send for requester 0 / 1, sampled on ack.
REQ-008 ack0_o / ack1_o  output  1  one-cycle pulse: request accepted, tx word latched.
REQ-009 done0_o / done1_o  output  1  one-cycle pulse: transfer complete, rx word valid.
REQ-010 rx0_o / rx1_o  output  DATA_W  last received word per requester, held until that requester's next done.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 cs  output  2  per-slave select to the SPI mux, active-low, at most one bit low.
REQ-013 SPI_CSN  output  1  master chip select, active-low.
REQ-014 SPI_CLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 SPI_MOSI  output  1  serial data out.
REQ-016 SPI_MISO  input  1  serial data in from the mux.

Function
REQ-017 States: IDLE, SETUP, SHIFT, HOLD, GAP; no other reachable state.
REQ-018 IDLE: SPI_CSN=1, cs=2'b11, SPI_CLK=0, SPI_MOSI=0.
REQ-019 IDLE with any req high: grant the requester chosen by round-robin, latch its tx word, pulse its ack in that cycle, go to SETUP next cycle.
REQ-020 Round-robin: if both requests are high, grant the requester not granted last; the last-granted pointer resets to 1, so requester 0 wins the first contention.
REQ-021 A single pending request is granted regardless of the pointer.
REQ-022 From SETUP through HOLD: cs[g]=0 for the granted g, the other cs bit=1, SPI_CSN=0.
REQ-023 SETUP lasts CLK_DIV cycles: SPI_CLK=0, SPI_MOSI=tx[DATA_W-1].
REQ-024 SHIFT lasts 2*DATA_W*CLK_DIV cycles; SPI_CLK toggles every CLK_DIV cycles, starting high.
REQ-025 On each SPI_CLK rising transition, sample SPI_MISO into the rx shift register LSB (shift left).
REQ-026 On each falling transition, present the next tx bit on SPI_MOSI; after the last falling edge, SPI_CLK=0 and SHIFT ends.
REQ-027 HOLD lasts CLK_DIV cycles: SPI_CLK=0, SPI_CSN=0.
REQ-028 On entry to GAP: SPI_CSN=1, cs=2'b11, rx_g updated, done_g pulses for exactly one cycle.
REQ-029 GAP lasts CS_GAP cycles, then IDLE.
REQ-030 done_g occurs exactly (2*DATA_W+2)*CLK_DIV+1 cycles after ack_g.
REQ-031 A new request is evaluated only in IDLE.
REQ-032 A request held high through a transfer is re-arbitrated in IDLE.
REQ-033 Requester inputs changing after ack have no effect on the current transfer.
REQ-034 SPI_CLK, SPI_MOSI, SPI_CSN and cs are driven from registers (glitch-free).
REQ-035 ack and done never pulse for both requesters in the same cycle.

Reset
REQ-036 While rst=1 and on the following cycle: state=IDLE, SPI_CSN=1, cs=2'b11, SPI_CLK=0, SPI_MOSI=0, ack*/done*/busy_o=0, rx0_o=rx1_o=0, round-robin pointer=1.
REQ-037 rst asserted mid-transfer aborts it: the REQ-036 values appear on the next edge, and no done pulse is issued for the aborted transfer.

Verification
REQ-038 Single transfer, defaults: req0=1, tx0=16'hA5C3, slave echoes 16'h3C5A.
  - ack0 pulses once.
  - MOSI bits match A5C3 MSB first on rising edges.
  - cs=2'b10; 16 SCLK pulses.
  - done0 fires 137 cycles after ack0; rx0_o=16'h3C5A.
REQ-039 Contention: req0=req1=1 held from reset.
  - Grants alternate 0,1,0,1.
  - cs alternates 2'b10 / 2'b01.
  - SPI_CSN high at least 2 cycles between transfers.
REQ-040 Divider edge: CLK_DIV=1, DATA_W=8.
  - SCLK period is 2 clk cycles.
  - done fires 19 cycles after ack.
REQ-041 Reset mid-transfer: assert rst during SHIFT bit 7.
  - Next cycle SPI_CSN=1, SPI_CLK=0, cs=2'b11.
  - No done pulse.
  - A subsequent request completes normally.
REQ-042 Input stability: change tx1 and drop req1 one cycle after ack1.
  - Transmitted word equals the value latched at ack1.
  - done1 still fires.
REQ-043 Idle check: no requests for 1000 cycles.
  - busy_o=0, SPI_CLK=0, SPI_CSN=1, no ack or done pulses.
